// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop line synchroniser, mid-bit sampling FSM and receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (even/odd selected by parity_odd).
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        rxclk,
  input  logic                        reset_n,
  input  logic                        rx_enable,
  input  logic                        rx_in,
  input  logic                        uld_rx_data,
  input  logic                        clr_err,
  input  logic                        parity_odd,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_empty,
  output logic                        rx_full,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        rx_frame_err,
  output logic                        rx_over_run,
  output logic                        rx_parity_err
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic                 rx_meta, rx_s;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 sample_pt, stop_pt, push, pop, frame_set, over_set;

  // NOTE: registers update with <= so every flop samples pre-edge values; '=' here would collapse the synchroniser into one stage.
  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign sample_pt = (sample_cnt == SW'(OVERSAMPLE/2 - 1));
  assign stop_pt   = rx_enable && (state == STOP) && sample_pt;
  assign pop       = uld_rx_data && (rx_count != '0);
  // A full FIFO still accepts the character when the head leaves in the same cycle.
  assign push      = stop_pt && rx_s && (!rx_full || pop);
  assign frame_set = stop_pt && !rx_s;
  assign over_set  = stop_pt && rx_s && rx_full && !pop;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_set;
  assign par_set = push && ((^shift_reg ^ parity_odd) != par_bit);

  always_ff @(posedge rxclk) begin
    if (!reset_n) rx_parity_err <= 1'b0;
    else          rx_parity_err <= par_set | (rx_parity_err & ~clr_err);
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign rx_parity_err     = 1'b0;
`endif

  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else if (!rx_enable) begin
      state <= IDLE;
    end else begin
      if (state != IDLE)
        sample_cnt <= (sample_cnt == SW'(OVERSAMPLE - 1)) ? '0 : sample_cnt + SW'(1);
      case (state)
        IDLE: if (!rx_s) begin
          state      <= START;
          sample_cnt <= '0;
          bit_cnt    <= '0;
        end
        START: if (sample_pt) state <= rx_s ? IDLE : DATA;
        DATA: if (sample_pt) begin
          shift_reg[bit_cnt] <= rx_s;
          bit_cnt            <= bit_cnt + BW'(1);
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == BW'(DATA_BITS - 1)) state <= PARITY;
`else
          if (bit_cnt == BW'(DATA_BITS - 1)) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (sample_pt) begin
          par_bit <= rx_s;
          state   <= STOP;
        end
`endif
        STOP: if (sample_pt) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only ever read after being written.
  always_ff @(posedge rxclk) begin
    if (push) fifo_mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rx_count     <= '0;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
      rx_over_run  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rx_data <= fifo_mem[rd_ptr];
        rd_ptr  <= rd_ptr + PW'(1);
      end
      if (push && !pop)      rx_count <= rx_count + CW'(1);
      else if (pop && !push) rx_count <= rx_count - CW'(1);
      rx_frame_err <= frame_set | (rx_frame_err & ~clr_err);
      rx_over_run  <= over_set  | (rx_over_run  & ~clr_err);
    end
  end

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: a queue-based receiver model compared every cycle plus directed literal checks.
// Works with or without UART_RX_PARITY_EN defined; a second instance covers 7-bit characters at 8x oversampling.
module tb_uart_rx_param;
  localparam int NB  = 8, OS  = 16, DEPTH  = 4;
  localparam int NB7 = 7, OS7 = 8,  DEPTH7 = 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic rxclk = 1'b0, reset_n = 1'b0, rx_enable = 1'b0, rx_in = 1'b1;
  logic uld_rx_data = 1'b0, clr_err = 1'b0, parity_odd = 1'b0;
  logic rx7 = 1'b1, uld7 = 1'b0;

  logic [NB-1:0]  rx_data;
  logic           rx_empty, rx_full, rx_frame_err, rx_over_run, rx_parity_err;
  logic [2:0]     rx_count;
  logic [NB7-1:0] rx_data7;
  logic           rx_empty7, rx_full7, rx_frame_err7, rx_over_run7, rx_parity_err7;
  logic [1:0]     rx_count7;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 rxclk = ~rxclk;

  uart_rx_param #(.DATA_BITS(NB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
    .rxclk(rxclk), .reset_n(reset_n), .rx_enable(rx_enable), .rx_in(rx_in),
    .uld_rx_data(uld_rx_data), .clr_err(clr_err), .parity_odd(parity_odd),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
    .rx_frame_err(rx_frame_err), .rx_over_run(rx_over_run), .rx_parity_err(rx_parity_err));

  uart_rx_param #(.DATA_BITS(NB7), .OVERSAMPLE(OS7), .FIFO_DEPTH(DEPTH7)) dut7 (
    .rxclk(rxclk), .reset_n(reset_n), .rx_enable(rx_enable), .rx_in(rx7),
    .uld_rx_data(uld7), .clr_err(clr_err), .parity_odd(parity_odd),
    .rx_data(rx_data7), .rx_empty(rx_empty7), .rx_full(rx_full7), .rx_count(rx_count7),
    .rx_frame_err(rx_frame_err7), .rx_over_run(rx_over_run7), .rx_parity_err(rx_parity_err7));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver model: FIFO contents as a queue, one pending character with the edge its stop bit is judged on.
  logic [7:0] q[$];
  logic [7:0] m_data;
  bit         m_fe, m_or, m_pe, live;
  bit         pend_valid;
  int         pend_edge;
  logic [7:0] pend_data;
  logic       pend_stop, pend_pbit;
  logic       s_rst, s_en, s_uld, s_clr, s_podd;

  always @(posedge rxclk) begin
    cyc    <= cyc + 1;
    s_rst  <= reset_n;
    s_en   <= rx_enable;
    s_uld  <= uld_rx_data;
    s_clr  <= clr_err;
    s_podd <= parity_odd;
  end

  always @(negedge rxclk) begin
    bit stop_evt, do_pop, do_push, fe_s, or_s, pe_s;
    if (s_rst === 1'b0) begin
      live = 1; q.delete(); m_data = '0; m_fe = 0; m_or = 0; m_pe = 0; pend_valid = 0;
    end else if (live) begin
      stop_evt = pend_valid && s_en && (cyc == pend_edge);
      do_pop   = s_uld && (q.size() > 0);
      do_push  = stop_evt && pend_stop && (q.size() < DEPTH || do_pop);
      fe_s     = stop_evt && !pend_stop;
      or_s     = stop_evt && pend_stop && !do_push;
      pe_s     = do_push && (P == 1) && (pend_pbit != (^pend_data ^ s_podd));
      if (do_pop)  m_data = q.pop_front();
      if (do_push) q.push_back(pend_data);
      m_fe = fe_s || (m_fe && !s_clr);
      m_or = or_s || (m_or && !s_clr);
      m_pe = pe_s || (m_pe && !s_clr);
      if (!s_en || cyc >= pend_edge) pend_valid = 0;
    end
    if (live) begin
      check("rx_data", rx_data, m_data);
      check("rx_count", rx_count, q.size());
      check("rx_empty", rx_empty, q.size() == 0);
      check("rx_full", rx_full, q.size() == DEPTH);
      check("rx_frame_err", rx_frame_err, m_fe);
      check("rx_over_run", rx_over_run, m_or);
      check("rx_parity_err", rx_parity_err, m_pe);
    end
  end

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  function automatic logic par_of(input logic [7:0] d, input int nb, input logic odd);
    logic p = odd;
    for (int i = 0; i < nb; i++) p ^= d[i];
    return p;
  endfunction

  // Drive one frame on line sel (0: main, 1: 7-bit instance). abort_kind 1 drops rx_enable, 2 pulses reset.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop_bit, input logic par_bit,
                            input int abort_at, input int abort_kind, input int uld_at);
    int nb, os, nbits, b;
    logic v;
    nb    = (sel == 0) ? NB : NB7;
    os    = (sel == 0) ? OS : OS7;
    nbits = nb + 2 + P;
    if (sel == 0) begin
      pend_valid = 1; pend_edge = cyc + 3 + os/2 + os*(nb + 1 + P);
      pend_data = d; pend_stop = stop_bit; pend_pbit = par_bit;
    end
    for (int i = 0; i < nbits*os; i++) begin
      if (i == abort_at) begin
        rx_in = 1'b1; rx7 = 1'b1;
        if (abort_kind == 1) begin
          rx_enable = 1'b0; repeat (4) tick(); rx_enable = 1'b1; repeat (OS) tick();
        end else begin
          reset_n = 1'b0; repeat (2) tick(); reset_n = 1'b1; tick();
        end
        return;
      end
      b = i / os;
      if (b == 0)                     v = 1'b0;
      else if (b <= nb)               v = d[b-1];
      else if (P == 1 && b == nb + 1) v = par_bit;
      else                            v = stop_bit;
      if (sel == 0) rx_in = v; else rx7 = v;
      uld_rx_data = (i == uld_at);
      tick();
    end
    uld_rx_data = 1'b0;
    rx_in = 1'b1; rx7 = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(0, d, 1'b1, par_of(d, NB, parity_odd), -1, 0, -1);
  endtask

  task automatic unload(input int sel);
    if (sel == 0) uld_rx_data = 1'b1; else uld7 = 1'b1;
    tick();
    uld_rx_data = 1'b0; uld7 = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick();
    repeat (3) tick();
    reset_n = 1'b1; rx_enable = 1'b1;
    repeat (2) tick();
    check("reset empty", rx_empty, 1);
    check("reset count", rx_count, 0);
    check("reset data", rx_data, 0);
    check("reset frame_err", rx_frame_err, 0);

    send(8'h55); repeat (2) tick();
    check("0x55 count", rx_count, 1);
    check("0x55 empty", rx_empty, 0);
    unload(0);
    check("0x55 data", rx_data, 8'h55);
    check("0x55 empty after unload", rx_empty, 1);

    rx_in = 1'b0; repeat (4) tick(); rx_in = 1'b1; repeat (20) tick();
    check("glitch count", rx_count, 0);
    check("glitch frame_err", rx_frame_err, 0);

    send_frame(0, 8'hA3, 1'b0, par_of(8'hA3, NB, parity_odd), -1, 0, -1);
    repeat (OS) tick();
    check("bad stop frame_err", rx_frame_err, 1);
    check("bad stop count", rx_count, 0);
    pulse_clr();
    check("clr frame_err", rx_frame_err, 0);

    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    check("overflow full", rx_full, 1);
    check("overflow over_run", rx_over_run, 1);
    check("overflow count", rx_count, 4);
    unload(0); check("fifo order 0", rx_data, 8'h11);
    unload(0); check("fifo order 1", rx_data, 8'h22);
    unload(0); check("fifo order 2", rx_data, 8'h33);
    unload(0); check("fifo order 3", rx_data, 8'h44);
    check("drained empty", rx_empty, 1);
    unload(0); check("unload when empty holds", rx_data, 8'h44);
    pulse_clr();

    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    send_frame(0, 8'h65, 1'b1, par_of(8'h65, NB, parity_odd), -1, 0, 2 + OS/2 + OS*(NB + 1 + P));
    check("full+pop data", rx_data, 8'h61);
    check("full+pop full", rx_full, 1);
    check("full+pop no over_run", rx_over_run, 0);
    unload(0); unload(0); unload(0); unload(0);
    check("full+pop last", rx_data, 8'h65);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(0, 8'h07, 1'b1, 1'b0, -1, 0, -1);
    check("parity err set", rx_parity_err, 1);
    check("parity char pushed", rx_count, 1);
    unload(0); check("parity char data", rx_data, 8'h07);
    pulse_clr();
    parity_odd = 1'b1;
    send_frame(0, 8'h0F, 1'b1, 1'b1, -1, 0, -1);
    check("odd parity ok", rx_parity_err, 0);
    unload(0); check("odd parity data", rx_data, 8'h0F);
    parity_odd = 1'b0;
`else
    send(8'h07);
    check("no parity err", rx_parity_err, 0);
    unload(0); check("0x07 data", rx_data, 8'h07);
`endif

    send_frame(0, 8'h3C, 1'b1, par_of(8'h3C, NB, parity_odd), 5*OS + 3, 1, -1);
    check("disable no push", rx_count, 0);
    send(8'h5A);
    check("after disable count", rx_count, 1);
    unload(0); check("after disable data", rx_data, 8'h5A);

    send(8'h88);
    send_frame(0, 8'hA3, 1'b0, par_of(8'hA3, NB, parity_odd), -1, 0, -1);
    repeat (OS) tick();
    check("pre-reset frame_err", rx_frame_err, 1);
    send_frame(0, 8'h99, 1'b1, par_of(8'h99, NB, parity_odd), 4*OS, 2, -1);
    check("mid reset data", rx_data, 0);
    check("mid reset count", rx_count, 0);
    check("mid reset empty", rx_empty, 1);
    check("mid reset frame_err", rx_frame_err, 0);
    send(8'hC6); unload(0);
    check("post reset frame", rx_data, 8'hC6);

    send_frame(1, 8'h2B, 1'b1, par_of(8'h2B, NB7, parity_odd), -1, 0, -1);
    send_frame(1, 8'h71, 1'b1, par_of(8'h71, NB7, parity_odd), -1, 0, -1);
    check("7b count", rx_count7, 2);
    check("7b full", rx_full7, 1);
    unload(1); check("7b data 0", rx_data7, 7'h2B);
    unload(1); check("7b data 1", rx_data7, 7'h71);
    check("7b empty", rx_empty7, 1);
    check("7b frame_err", rx_frame_err7, 0);
    check("7b parity_err", rx_parity_err7, 0);

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
